// File: rtl/collector_pkg.sv
// Shared types and defaults for the MSB-first serial word collector.
package collector_pkg;

    localparam int COLLECTOR_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/collector_shift_reg.sv
// Shift-in-LSB register with a bit counter that wraps to zero after the last bit of a word.
module collector_shift_reg #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] sreg_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Clear wins over shift so a restart discards a bit offered in the same cycle.
    always_comb begin
        sreg_d  = sreg_q;
        count_d = count_q;
        if (clr_i) begin
            sreg_d  = '0;
            count_d = '0;
        end else if (shift_i) begin
            sreg_d = {sreg_q[WIDTH-2:0], bit_i};
            if (count_q == CNT_W'(WIDTH - 1)) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q  <= '0;
            count_q <= '0;
        end else begin
            sreg_q  <= sreg_d;
            count_q <= count_d;
        end
    end

    assign sreg_o  = sreg_q;
    assign count_o = count_q;

endmodule

// File: rtl/serial_word_collector.sv
// MSB-first serial-to-parallel collector with a one-word valid/ready output slot and bit backpressure.
module serial_word_collector
    import collector_pkg::*;
#(
    parameter  int WIDTH = COLLECTOR_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] word_out,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state_q;
    logic [WIDTH-1:0] word_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] word_next;
    logic             slot_free;
    logic             bit_xfer;
    logic             last_bit;
    logic             clr;

    assign bit_ready = (state_q == COLLECT);
    assign busy      = (state_q != IDLE);
    assign slot_free = !out_valid_q || out_ready;

    // start outranks a bit offered in the same cycle; in HOLD start is ignored entirely.
    assign bit_xfer  = bit_valid && bit_ready && !start;
    assign last_bit  = bit_xfer && (count == CNT_W'(WIDTH - 1));
    assign clr       = start && (state_q != HOLD);
    assign word_next = {sreg[WIDTH-2:0], bit_in};

    collector_shift_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .shift_i (bit_xfer),
        .bit_i   (bit_in),
        .sreg_o  (sreg),
        .count_o (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // A delivered word frees the slot unless a new word lands on the same edge.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (!start && last_bit) begin
                        if (slot_free) begin
                            word_q      <= word_next;
                            out_valid_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        word_q      <= sreg;
                        out_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign word_out  = word_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Scoreboard bench for serial_word_collector at WIDTH=16 and WIDTH=2.
module tb_serial_word_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, bit_valid, bit_in, out_ready;
    logic        bit_ready, busy, out_valid;
    logic [3:0]  count;
    logic [15:0] word_out;

    logic        start2, bit_valid2, bit_in2, out_ready2;
    logic        bit_ready2, busy2, out_valid2;
    logic [0:0]  count2;
    logic [1:0]  word_out2;

    int total = 0;
    int bad   = 0;

    logic [15:0] q16[$];
    logic [1:0]  q2[$];
    logic [15:0] sb_exp16;
    logic [1:0]  sb_exp2;

    always #5 clk = ~clk;

    serial_word_collector #(.WIDTH(16)) u16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .bit_ready (bit_ready),
        .busy      (busy),
        .count     (count),
        .word_out  (word_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    serial_word_collector #(.WIDTH(2)) u2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start2),
        .bit_valid (bit_valid2),
        .bit_in    (bit_in2),
        .bit_ready (bit_ready2),
        .busy      (busy2),
        .count     (count2),
        .word_out  (word_out2),
        .out_valid (out_valid2),
        .out_ready (out_ready2)
    );

    // Word transfers are popped from the scoreboard half a cycle before the accepting edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (q16.size() == 0) begin
                bad++;
                $display("FAIL sb16_unexpected: word_out=%h, no word expected", word_out);
            end else begin
                sb_exp16 = q16.pop_front();
                if (word_out !== sb_exp16) begin
                    bad++;
                    $display("FAIL sb16_word: got %h expected %h", word_out, sb_exp16);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid2 && out_ready2) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL sb2_unexpected: word_out=%b, no word expected", word_out2);
            end else begin
                sb_exp2 = q2.pop_front();
                if (word_out2 !== sb_exp2) begin
                    bad++;
                    $display("FAIL sb2_word: got %b expected %b", word_out2, sb_exp2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic bv);
        start     = 1'b1;
        bit_valid = bv;
        bit_in    = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic send16(input logic [15:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            bit_valid = 1'b1;
            bit_in    = w[i];
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b0;
        start2 = 1'b0; bit_valid2 = 1'b0; bit_in2 = 1'b0; out_ready2 = 1'b0;
        #2;
        total++;
        if ({busy, bit_ready, out_valid, count, word_out} !== '0) begin
            bad++;
            $display("FAIL reset16: busy=%b rdy=%b ov=%b cnt=%0d word=%h expected all 0",
                     busy, bit_ready, out_valid, count, word_out);
        end
        total++;
        if ({busy2, bit_ready2, out_valid2, count2, word_out2} !== '0) begin
            bad++;
            $display("FAIL reset2: busy=%b rdy=%b ov=%b cnt=%0d word=%b expected all 0",
                     busy2, bit_ready2, out_valid2, count2, word_out2);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (bit_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: rdy=%b busy=%b expected 0 0", bit_ready, busy);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        do_start(1'b1);
        total++;
        if (count !== 4'd0 || busy !== 1'b1 || bit_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_start: cnt=%0d busy=%b rdy=%b expected 0 1 1", count, busy, bit_ready);
        end
        q16.push_back(16'hA5C3);
        send16(16'hA5C3, 15, 0);
        total++;
        if (out_valid !== 1'b1 || word_out !== 16'hA5C3 || busy !== 1'b0 || count !== 4'd0) begin
            bad++;
            $display("FAIL basic_done: ov=%b word=%h busy=%b cnt=%0d expected 1 a5c3 0 0",
                     out_valid, word_out, busy, count);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain: ov=%b expected 0", out_valid);
        end
    endtask

    task automatic test_gaps();
        logic [15:0] w;
        logic [3:0]  ec;
        w  = 16'hA5C3;
        ec = 4'd0;
        out_ready = 1'b1;
        do_start(1'b0);
        q16.push_back(w);
        for (int i = 15; i >= 0; i--) begin
            bit_valid = 1'b1;
            bit_in    = w[i];
            tick();
            ec = ec + 4'd1;
            total++;
            if (count !== ec) begin
                bad++;
                $display("FAIL gaps_cnt_valid bit%0d: cnt=%0d expected %0d", i, count, ec);
            end
            if (i == 0) begin
                total++;
                if (out_valid !== 1'b1 || word_out !== w) begin
                    bad++;
                    $display("FAIL gaps_word: ov=%b word=%h expected 1 %h", out_valid, word_out, w);
                end
            end
            bit_valid = 1'b0;
            bit_in    = ~bit_in;
            tick();
            total++;
            if (count !== ec) begin
                bad++;
                $display("FAIL gaps_cnt_gap bit%0d: cnt=%0d expected %0d", i, count, ec);
            end
        end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        do_start(1'b0);
        q16.push_back(16'h1234);
        send16(16'h1234, 15, 0);
        total++;
        if (out_valid !== 1'b1 || word_out !== 16'h1234) begin
            bad++;
            $display("FAIL hold_first: ov=%b word=%h expected 1 1234", out_valid, word_out);
        end
        do_start(1'b0);
        q16.push_back(16'hFFFF);
        send16(16'hFFFF, 15, 0);
        total++;
        if (busy !== 1'b1 || bit_ready !== 1'b0 || word_out !== 16'h1234 || count !== 4'd0) begin
            bad++;
            $display("FAIL hold_state: busy=%b rdy=%b word=%h cnt=%0d expected 1 0 1234 0",
                     busy, bit_ready, word_out, count);
        end
        do_start(1'b1);
        total++;
        if (busy !== 1'b1 || bit_ready !== 1'b0 || word_out !== 16'h1234 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_start_ignored: busy=%b rdy=%b word=%h ov=%b expected 1 0 1234 1",
                     busy, bit_ready, word_out, out_valid);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (word_out !== 16'hFFFF || out_valid !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL hold_release: word=%h ov=%b busy=%b expected ffff 1 0", word_out, out_valid, busy);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_drain: ov=%b expected 0", out_valid);
        end
    endtask

    task automatic test_restart();
        out_ready = 1'b1;
        do_start(1'b0);
        send16(16'hDEAD, 15, 11);
        total++;
        if (count !== 4'd5) begin
            bad++;
            $display("FAIL restart_partial: cnt=%0d expected 5", count);
        end
        do_start(1'b1);
        total++;
        if (count !== 4'd0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL restart_clear: cnt=%0d busy=%b ov=%b expected 0 1 0", count, busy, out_valid);
        end
        q16.push_back(16'h0F0F);
        send16(16'h0F0F, 15, 0);
        total++;
        if (word_out !== 16'h0F0F || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL restart_word: word=%h ov=%b expected 0f0f 1", word_out, out_valid);
        end
        tick();
        do_start(1'b0);
        send16(16'h7777, 15, 1);
        total++;
        if (count !== 4'd15) begin
            bad++;
            $display("FAIL restart_last_cnt: cnt=%0d expected 15", count);
        end
        do_start(1'b1);
        total++;
        if (count !== 4'd0 || out_valid !== 1'b0 || bit_ready !== 1'b1) begin
            bad++;
            $display("FAIL restart_last_bit_ignored: cnt=%0d ov=%b rdy=%b expected 0 0 1",
                     count, out_valid, bit_ready);
        end
        q16.push_back(16'h3C5A);
        send16(16'h3C5A, 15, 0);
        total++;
        if (word_out !== 16'h3C5A || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL restart_word2: word=%h ov=%b expected 3c5a 1", word_out, out_valid);
        end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        do_start(1'b0);
        send16(16'hBEEF, 15, 7);
        total++;
        if (count !== 4'd9) begin
            bad++;
            $display("FAIL areset_pre: cnt=%0d expected 9", count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, bit_ready, out_valid, count, word_out} !== '0) begin
            bad++;
            $display("FAIL areset_immediate: busy=%b rdy=%b ov=%b cnt=%0d word=%h expected all 0",
                     busy, bit_ready, out_valid, count, word_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            tick();
            total++;
            if (bit_ready !== 1'b0 || count !== 4'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL areset_no_start cyc%0d: rdy=%b cnt=%0d busy=%b ov=%b expected 0 0 0 0",
                         k, bit_ready, count, busy, out_valid);
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic test_w2();
        out_ready2 = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        bit_valid2 = 1'b1; bit_in2 = 1'b1;
        tick();
        bit_in2 = 1'b0;
        tick();
        bit_valid2 = 1'b0;
        total++;
        if (word_out2 !== 2'b10 || out_valid2 !== 1'b1 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL w2_first: word=%b ov=%b busy=%b expected 10 1 0", word_out2, out_valid2, busy2);
        end
        q2.push_back(2'b10);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        q2.push_back(2'b01);
        bit_valid2 = 1'b1; bit_in2 = 1'b0;
        tick();
        bit_in2 = 1'b1;
        out_ready2 = 1'b1;
        tick();
        bit_valid2 = 1'b0;
        total++;
        if (word_out2 !== 2'b01 || out_valid2 !== 1'b1 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL w2_overlap: word=%b ov=%b busy=%b expected 01 1 0", word_out2, out_valid2, busy2);
        end
        tick();
        total++;
        if (out_valid2 !== 1'b0) begin
            bad++;
            $display("FAIL w2_drain: ov=%b expected 0", out_valid2);
        end
        out_ready2 = 1'b0;
    endtask

    task automatic test_scoreboard_empty();
        tick();
        total++;
        if (q16.size() != 0 || q2.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: q16=%0d q2=%0d expected 0 0", q16.size(), q2.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_hold();
        test_restart();
        test_async_reset();
        test_w2();
        test_scoreboard_empty();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
